ysyx_25060170_idu_opq: RTL
==========================

# ysyx_25060170_idu_opq

Parametrised successor to the single-cycle decode/forward stage. It takes decoded instructions from IF/ID, resolves source operands against the register file and N prioritised forwarding sources, and stalls on pending (not-yet-available) producers. Accepted instructions go into a registered two-entry ID→EX queue (main + skid) with valid/ready handshakes on both sides. The registered `id_ready` breaks the EX→IF ready path, and flush kills everything in flight.

## Interface
- XLEN, 32, operand/data width
- NFWD, 3, forwarding sources; index 0 = youngest, highest priority
- PW, 64, opaque payload width (pc, imm, control bits), passed through unchanged
- SCNT_W, 16, stall-counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- if_valid  in  1  upstream instruction valid
- id_ready  out  1  registered; stage can accept this cycle
- rs1_ena, rs2_ena  in  1 each  source used
- rs1_addr, rs2_addr  in  5 each  source register
- rs1_data, rs2_data  in  XLEN each  regfile read data, same cycle
- rd_ena  in  1, rd_addr  in  5  destination, passed through
- payload_i  in  PW  passthrough
- fwd_valid  in  NFWD  source i holds a live write to fwd_addr[i]
- fwd_pending  in  NFWD  source i's data not yet available, e.g. load in EX
- fwd_addr  in  5*NFWD  packed, slot i at [5i+4:5i]
- fwd_data  in  XLEN*NFWD  packed, slot i at [XLEN*i+XLEN-1:XLEN*i]
- flush  in  1  kill queue contents and the incoming instruction
- ex_ready  in  1  downstream accepts
- ex_valid  out  1  queue head valid
- op1, op2  out  XLEN each  resolved operands of head
- rd_ena_o, rd_addr_o, payload_o  out  head fields
- hazard  out  1  combinational; incoming instruction blocked by pending producer
- stall_cnt  out  SCNT_W  saturating count of hazard cycles

## Operation
- Operand resolution, per source s (combinational):
  - !s_ena or addr==0 → operand 0.
  - Otherwise take the lowest index i with fwd_valid[i] and fwd_addr[i]==addr.
  - If a match exists and fwd_pending[i]=0 → fwd_data[i].
  - If a match exists and fwd_pending[i]=1 → blocked; an older non-pending match never overrides a younger pending one.
  - No match → rs_data.
- hazard = if_valid & (rs1 blocked | rs2 blocked). Forced 0 while rst is asserted.
- accept = if_valid & id_ready & !hazard & !flush. On accept, the resolved op1/op2, rd fields and payload are captured into the queue.
- pop = ex_valid & ex_ready & !flush.
- Queue FSM:
  - EMPTY: accept → ONE.
  - ONE: accept & !pop → TWO (incoming goes to skid). accept & pop → ONE (incoming into main). pop only → EMPTY.
  - TWO: pop → ONE (skid moves to main); no accept is possible.
- Order is strict FIFO; the head is always the main entry.
- id_ready is a flop, equal to (next state != TWO).
- flush, any state → EMPTY. flush wins over simultaneous accept and pop. id_ready=1 on the following cycle.
- stall_cnt increments in each cycle with hazard=1 and saturates at 2^SCNT_W−1. It is cleared only by reset; flush does not clear it.
- Captured operands are not refreshed while held in the queue.

## Timing
- Reset values: state EMPTY, ex_valid=0, id_ready=1, op1=op2=0, rd_ena_o=0, rd_addr_o=0, payload_o=0, stall_cnt=0. Skid contents are zeroed.
- Reset mid-operation clears the queue immediately (asynchronous).
- Latency: accepted at edge N → ex_valid=1 with its data after edge N.
- Pass-through: one accept and one pop per cycle.
- hazard is a same-cycle function of its inputs. All other outputs come straight from flops, with no combinational path from ex_ready.
- Handshake rules:
  - Upstream must hold if_valid and its fields stable until accepted or flushed.
  - ex_valid and head data stay stable until popped or flushed.

## Test plan
- Forward priority: rs1=5 used; fwd0 {valid, addr 5, data 0xA}, fwd1 {valid, addr 5, data 0xB}; rs1_data=0xC; ex_ready=1 → next cycle ex_valid=1, op1=0xA. With fwd0 invalid → op1=0xB. With no match → op1=0xC. With rs1=0 → op1=0.
- Load-use stall: fwd0 {valid, pending, addr 7}, incoming rs2=7 → hazard=1 and no accept. stall_cnt +1 per cycle for 3 cycles. Then pending=0, fwd_data=0x55 → accepted, op2=0x55, stall_cnt=3.
- Backpressure/skid: ex_ready=0, two back-to-back accepts → id_ready=0 after the second edge. Raise ex_ready → outputs A then B in order; id_ready=1 one cycle after the first pop.
- Full throughput: ex_ready=1, 8 consecutive instructions → 8 pops on 8 consecutive cycles after a 1-cycle latency, with no bubbles.
- Flush: state TWO plus if_valid=1, assert flush 1 cycle → ex_valid=0 next cycle, id_ready=1, no instruction emitted.
- Reset: assert rst=0 asynchronously mid-stream → ex_valid and stall_cnt drop to 0 immediately, without a clock edge.
- Saturation: SCNT_W=4, hazard held 20 cycles → stall_cnt=15.

Source files
------------

// File: rtl/ysyx_25060170_idu_opq.sv
// Decode-stage operand resolver feeding a two-entry (main + skid) ID->EX queue.
// Operands are resolved against N prioritised forwarding sources; pending producers stall.
module ysyx_25060170_idu_opq #(
  parameter int XLEN   = 32,
  parameter int NFWD   = 3,
  parameter int PW     = 64,
  parameter int SCNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_valid,
  output logic                 id_ready,
  input  logic                 rs1_ena,
  input  logic                 rs2_ena,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic                 rd_ena,
  input  logic [4:0]           rd_addr,
  input  logic [PW-1:0]        payload_i,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_pending,
  input  logic [5*NFWD-1:0]    fwd_addr,
  input  logic [XLEN*NFWD-1:0] fwd_data,
  input  logic                 flush,
  input  logic                 ex_ready,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      op1,
  output logic [XLEN-1:0]      op2,
  output logic                 rd_ena_o,
  output logic [4:0]           rd_addr_o,
  output logic [PW-1:0]        payload_o,
  output logic                 hazard,
  output logic [SCNT_W-1:0]    stall_cnt
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            rd_ena;
    logic [4:0]      rd_addr;
    logic [PW-1:0]   pl;
  } ent_t;

  // Returns {blocked, value}. Walking from oldest to youngest lets the youngest
  // match win, so an older ready copy can never mask a younger pending one.
  function automatic logic [XLEN:0] resolve(
    input logic                 ena,
    input logic [4:0]           addr,
    input logic [XLEN-1:0]      rdat,
    input logic [NFWD-1:0]      fv,
    input logic [NFWD-1:0]      fp,
    input logic [5*NFWD-1:0]    fa,
    input logic [XLEN*NFWD-1:0] fd
  );
    logic [XLEN:0] r;
    r = {1'b0, rdat};
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fv[i] && (fa[5*i +: 5] == addr)) r = {fp[i], fd[XLEN*i +: XLEN]};
    end
    if (!ena || (addr == 5'd0)) r = '0;
    return r;
  endfunction

  state_e              state_q, state_d;
  ent_t                main_q, main_d, skid_q, skid_d, inc;
  logic                vld_q, rdy_q;
  logic [SCNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]       r1, r2;
  logic                accept, pop;

  always_comb begin
    r1 = resolve(rs1_ena, rs1_addr, rs1_data, fwd_valid, fwd_pending, fwd_addr, fwd_data);
    r2 = resolve(rs2_ena, rs2_addr, rs2_data, fwd_valid, fwd_pending, fwd_addr, fwd_data);
    inc         = '0;
    inc.op1     = r1[XLEN-1:0];
    inc.op2     = r2[XLEN-1:0];
    inc.rd_ena  = rd_ena;
    inc.rd_addr = rd_addr;
    inc.pl      = payload_i;
  end

  // Gated by rst so an asynchronous reset cannot leak a stall upstream.
  assign hazard = rst & if_valid & (r1[XLEN] | r2[XLEN]);
  assign accept = if_valid & rdy_q & ~hazard & ~flush;
  assign pop    = vld_q & ex_ready & ~flush;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) begin state_d = S_ONE; main_d = inc; end
        S_ONE: begin
          if (accept && !pop)     begin state_d = S_TWO; skid_d = inc; end
          else if (accept && pop) main_d = inc;
          else if (pop)           state_d = S_EMPTY;
        end
        S_TWO:   if (pop) begin state_d = S_ONE; main_d = skid_q; end
        default: state_d = S_EMPTY;
      endcase
    end
    cnt_d = (hazard && (cnt_q != {SCNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      vld_q   <= (state_d != S_EMPTY);
      rdy_q   <= (state_d != S_TWO);
      cnt_q   <= cnt_d;
    end
  end

  assign id_ready  = rdy_q;
  assign ex_valid  = vld_q;
  assign op1       = main_q.op1;
  assign op2       = main_q.op2;
  assign rd_ena_o  = main_q.rd_ena;
  assign rd_addr_o = main_q.rd_addr;
  assign payload_o = main_q.pl;
  assign stall_cnt = cnt_q;

endmodule
